// File: rtl/img_rom_arbiter.sv
// rtl/img_rom_arbiter.sv - three-requester round-robin arbiter for a synchronous image ROM
//
// Purpose: shares one synchronous single-port image ROM between the background
// scan (requester 0) and two sprite engines (requesters 1-2). A request wins at
// edge k, gnt/mem_addr are presented for the cycle after edge k, and
// rvalid/rdata for the cycle after edge k+1. Also counts grants per frame.
//
// Optional feature macro: IMG_ROM_ARB_BG_PRIO_EN
//   defined   : requester 0 wins whenever eligible; 1 and 2 round-robin.
//   undefined : plain 3-way round-robin.
//
// Ports:
//   Clk        - system clock, rising edge
//   Reset_n    - asynchronous active-low reset
//   frame_clk  - frame strobe level, rising edge detected on Clk
//   req[2:0]   - per-requester read request
//   addr0..2   - per-requester read address
//   gnt[2:0]   - one-hot registered grant pulse
//   rvalid[2:0]- one-hot read-data-valid pulse
//   rdata      - shared read data (zero unless an rvalid bit is high)
//   mem_addr   - registered ROM address
//   mem_data   - ROM output, valid one Clk after mem_addr
//   busy       - any gnt or rvalid bit high
//   grant_cnt  - grants issued in the previous frame
module img_rom_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_clk,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          busy,
  output logic [15:0]   grant_cnt
);

  logic [2:0]    rr_ptr;
  logic [2:0]    next_ptr;
  logic [2:0]    elig;
  logic [2:0]    win;
  logic [2:0]    slot;
  logic [AW-1:0] sel_addr;
  logic          frame_q;
  logic          frame_rise;
  logic [15:0]   run_cnt;

  // A requester granted in the current cycle sits out this edge, which caps
  // each requester at one grant every two cycles.
  assign elig       = req & ~gnt;
  assign frame_rise = frame_clk & ~frame_q;

  always_comb begin
    win      = 3'b000;
    next_ptr = rr_ptr;
    slot     = 3'd0;
`ifdef IMG_ROM_ARB_BG_PRIO_EN
    // Background always first; the pointer only arbitrates between sprites.
    if (elig[0]) begin
      win = 3'b001;
    end else if (rr_ptr == 3'd2) begin
      if (elig[2])      win = 3'b100;
      else if (elig[1]) win = 3'b010;
    end else begin
      if (elig[1])      win = 3'b010;
      else if (elig[2]) win = 3'b100;
    end
    if (win[1])      next_ptr = 3'd2;
    else if (win[2]) next_ptr = 3'd0;
`else
    // Search pointer, pointer+1, pointer+2 (mod 3); first eligible wins.
    for (int k = 0; k < 3; k++) begin
      slot = rr_ptr + 3'(k);
      if (slot >= 3'd3) slot = slot - 3'd3;
      if ((win == 3'b000) && elig[slot[1:0]]) win[slot[1:0]] = 1'b1;
    end
    if (win[0])      next_ptr = 3'd1;
    else if (win[1]) next_ptr = 3'd2;
    else if (win[2]) next_ptr = 3'd0;
`endif
  end

  always_comb begin
    sel_addr = mem_addr;
    unique case (1'b1)
      win[0]:  sel_addr = addr0;
      win[1]:  sel_addr = addr1;
      win[2]:  sel_addr = addr2;
      default: sel_addr = mem_addr;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt       <= 3'b000;
      rvalid    <= 3'b000;
      mem_addr  <= '0;
      rr_ptr    <= 3'd0;
      frame_q   <= 1'b0;
      run_cnt   <= 16'd0;
      grant_cnt <= 16'd0;
    end else begin
      gnt     <= win;
      // The requester recorded at grant time receives the data, whether or
      // not it still holds req.
      rvalid  <= gnt;
      frame_q <= frame_clk;
      if (|win) begin
        mem_addr <= sel_addr;
        rr_ptr   <= next_ptr;
      end
      // A grant coinciding with the frame edge belongs to the new frame.
      if (frame_rise) begin
        grant_cnt <= run_cnt;
        run_cnt   <= {15'd0, |win};
      end else if ((|win) && (run_cnt != 16'hFFFF)) begin
        run_cnt <= run_cnt + 16'd1;
      end
    end
  end

  // The ROM registers its own output, so read data is passed straight
  // through during the rvalid cycle.
  assign rdata = (|rvalid) ? mem_data : '0;
  assign busy  = (|gnt) | (|rvalid);

endmodule

// File: tb/tb_img_rom_arbiter.sv
// tb/tb_img_rom_arbiter.sv - scoreboard bench for img_rom_arbiter
module tb_img_rom_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          Clk;
  logic          Reset_n;
  logic          frame_clk;
  logic [2:0]    req;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [2:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy;
  logic [15:0]   grant_cnt;

  int passed = 0;
  int total  = 0;

  logic [21:0] gq[$];   // {gnt, mem_addr}
  logic [10:0] rq[$];   // {rvalid, rdata}
  logic [2:0]  seq[6];

  img_rom_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .grant_cnt(grant_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
    if (a == 19'd1000) return 8'h5A;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge Clk) mem_data <= rom_f(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [AW-1:0] addr_of(input logic [2:0] g);
    if (g == 3'b001) return addr0;
    if (g == 3'b010) return addr1;
    return addr2;
  endfunction

  task automatic expect_grant(input logic [2:0] g);
    logic [AW-1:0] a;
    a = addr_of(g);
    gq.push_back({g, a});
    rq.push_back({g, rom_f(a)});
  endtask

  // Monitor: pops an expectation whenever the DUT presents gnt or rvalid.
  always @(negedge Clk) begin
    logic [21:0] eg;
    logic [10:0] er;
    if (gnt != 3'b000) begin
      if (gq.size() == 0) begin
        chk("gnt_unexpected", {29'd0, gnt}, 32'd0);
      end else begin
        eg = gq.pop_front();
        chk("gnt", {29'd0, gnt}, {29'd0, eg[21:19]});
        chk("mem_addr", {13'd0, mem_addr}, {13'd0, eg[18:0]});
      end
    end
    if (rvalid != 3'b000) begin
      if (rq.size() == 0) begin
        chk("rvalid_unexpected", {29'd0, rvalid}, 32'd0);
      end else begin
        er = rq.pop_front();
        chk("rvalid", {29'd0, rvalid}, {29'd0, er[10:8]});
        chk("rdata", {24'd0, rdata}, {24'd0, er[7:0]});
      end
    end
    if ((gnt != 3'b000) || (rvalid != 3'b000)) chk("busy_high", {31'd0, busy}, 32'd1);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {29'd0, gnt}, 32'd0);
    chk({tag, "_rvalid"}, {29'd0, rvalid}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    chk({tag, "_mem_addr"}, {13'd0, mem_addr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_grant_cnt"}, {16'd0, grant_cnt}, 32'd0);
  endtask

  initial begin
`ifdef IMG_ROM_ARB_BG_PRIO_EN
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b001;
    seq[3] = 3'b100; seq[4] = 3'b001; seq[5] = 3'b010;
`else
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
    seq[3] = 3'b001; seq[4] = 3'b010; seq[5] = 3'b100;
`endif
    Reset_n = 1'b0; frame_clk = 1'b0; req = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Single background read, fixed 2-cycle latency.
    addr0 = 19'd1000;
    req   = 3'b001;
    expect_grant(3'b001);
    tick();
    req = 3'b000;
    chk("t1_gnt", {29'd0, gnt}, 32'd1);
    chk("t1_rvalid_early", {29'd0, rvalid}, 32'd0);
    tick();
    chk("t1_rvalid", {29'd0, rvalid}, 32'd1);
    chk("t1_rdata", {24'd0, rdata}, 32'h5A);
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);

    // Reset pulsed during the gnt=010 cycle discards the read.
    addr1 = 19'd2222;
    req   = 3'b010;
    gq.push_back({3'b010, 19'd2222});
    tick();
    req = 3'b000;
    chk("t2_gnt", {29'd0, gnt}, 32'd2);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Pointer back at 0: full round-robin from the first edge after release.
    addr0 = 19'd100; addr1 = 19'd200; addr2 = 19'd300;
    req   = 3'b111;
    for (int i = 0; i < 6; i++) expect_grant(seq[i]);
    repeat (6) tick();
    req = 3'b000;
    chk("t3_no_rvalid_after_reset", {29'd0, rvalid}, 32'd1 << (seq[4] == 3'b001 ? 0 : (seq[4] == 3'b010 ? 1 : 2)));
    repeat (3) tick();

    // Sprite 2 drops req right after its grant; data still delivered.
    addr2 = 19'd4444;
    req   = 3'b100;
    expect_grant(3'b100);
    tick();
    req = 3'b000;
    tick();
    chk("t4_rvalid_after_drop", {29'd0, rvalid}, 32'd4);
    repeat (2) tick();

    // Frame counting: 7 grants since the reset release, then 37, 0, 1.
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    chk("frame_cnt_7", {16'd0, grant_cnt}, 32'd7);
    addr0 = 19'd77;
    req   = 3'b001;
    for (int i = 0; i < 37; i++) expect_grant(3'b001);
    repeat (73) tick();
    req = 3'b000;
    repeat (3) tick();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    chk("frame_cnt_37", {16'd0, grant_cnt}, 32'd37);
    repeat (2) tick();
    frame_clk = 1'b1;
    req = 3'b001;
    expect_grant(3'b001);
    tick();
    frame_clk = 1'b0;
    req = 3'b000;
    chk("frame_cnt_0", {16'd0, grant_cnt}, 32'd0);
    repeat (3) tick();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
    chk("frame_cnt_same_edge", {16'd0, grant_cnt}, 32'd1);

    repeat (3) tick();
    chk("gnt_queue_drained", gq.size(), 32'd0);
    chk("rvalid_queue_drained", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
